// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU instruction fetch path.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DROP
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/cpu_instr_fetch_if.sv
// Instruction memory and decode-side handshake bundle for the fetch unit.
interface cpu_instr_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/cpu_instr_fetch.sv
// Instruction fetch FSM: one outstanding memory request, drives the external PC
// register, and discards responses that a redirect has made stale.
module cpu_instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_ld,
    output logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    cpu_instr_fetch_if.master     bus
);

    fetch_state_t          state;
    fetch_state_t          state_next;
    fetch_state_t          resume;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] instr_pc_q;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  req_fire;
    logic                  rsp_take;
    logic                  req_valid_c;
    logic [ADDR_WIDTH-1:0] req_addr_c;
    logic                  instr_valid_c;

    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);
    assign pc_inc           = pc + ADDR_WIDTH'(INSTR_BYTES);
    assign req_fire         = (state == REQ) && bus.mem_req_ready;
    assign rsp_take         = (state == WAIT) && bus.mem_rsp_valid && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                instr_pc_q <= pc;
            end
            if (rsp_take) begin
                instr_q <= bus.mem_rsp_data;
            end
        end
    end

    // After an abandoned or discarded transaction, resume fetching only while enabled.
    always_comb begin
        state_next    = state;
        resume        = en ? REQ : IDLE;
        pc_ld         = 1'b0;
        pc_next       = '0;
        req_valid_c   = 1'b0;
        req_addr_c    = '0;
        instr_valid_c = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                req_valid_c = 1'b1;
                req_addr_c  = pc;
                if (bus.mem_req_ready) begin
                    state_next = redirect_valid ? DROP : WAIT;
                end else if (redirect_valid) begin
                    state_next = resume;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_next = bus.mem_rsp_valid ? resume : DROP;
                end else if (bus.mem_rsp_valid) begin
                    state_next = OUT;
                    pc_ld      = 1'b1;
                    pc_next    = pc_inc;
                end
            end
            OUT: begin
                instr_valid_c = 1'b1;
                if (redirect_valid || bus.instr_ready) begin
                    state_next = resume;
                end
            end
            DROP: begin
                if (bus.mem_rsp_valid) begin
                    state_next = resume;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_ld   = 1'b1;
            pc_next = redirect_aligned;
        end

        // Outputs are forced quiet while reset is held, whatever the stale state says.
        if (!rst_n) begin
            state_next    = IDLE;
            pc_ld         = 1'b0;
            pc_next       = '0;
            req_valid_c   = 1'b0;
            req_addr_c    = '0;
            instr_valid_c = 1'b0;
        end
    end

    assign bus.mem_req_valid = req_valid_c;
    assign bus.mem_req_addr  = req_addr_c;
    assign bus.instr_valid   = instr_valid_c;
    assign bus.instr         = instr_q;
    assign bus.instr_pc      = instr_pc_q;

endmodule

// File: tb/tb_cpu_instr_fetch.sv
// Directed bench for cpu_instr_fetch with a PC register model and an
// expected-instruction queue popped on every decode handshake.
module tb_cpu_instr_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] pc;
    logic        pc_ld;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        o_pc_ld;
    logic [31:0] o_pc_next;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;

    int   checks;
    int   errors;
    int   hs_count;
    int   hs_before;
    exp_t sb_q[$];

    cpu_instr_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cpu_instr_fetch #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .pc            (pc),
        .pc_ld         (pc_ld),
        .pc_next       (pc_next),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] data, input logic [31:0] addr);
        exp_t e;
        e.instr = data;
        e.pc    = addr;
        sb_q.push_back(e);
    endtask

    // One clock: drive at negedge, sample settled outputs, then model the PC register.
    task automatic step(input logic r, input logic e, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic sv, input logic [31:0] sd, input logic ir);
        exp_t got;
        @(negedge clk);
        rst_n              = r;
        en                 = e;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        bus.mem_req_ready  = rdy;
        bus.mem_rsp_valid  = sv;
        bus.mem_rsp_data   = sd;
        bus.instr_ready    = ir;
        #1;
        o_req_valid   = bus.mem_req_valid;
        o_req_addr    = bus.mem_req_addr;
        o_pc_ld       = pc_ld;
        o_pc_next     = pc_next;
        o_instr_valid = bus.instr_valid;
        o_instr       = bus.instr;
        o_instr_pc    = bus.instr_pc;
        if (o_req_valid && rdy) hs_count++;
        if (o_instr_valid && ir) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("[TB] FAIL sb_underflow: observed instr %0h expected no delivery", o_instr);
            end
            if (sb_q.size() > 0) begin
                got = sb_q.pop_front();
                check("sb_instr", o_instr, got.instr);
                check("sb_instr_pc", o_instr_pc, got.pc);
            end
        end
        @(posedge clk);
        #1;
        if (o_pc_ld) pc = o_pc_next;
    endtask

    task automatic go(input logic e, input logic rdy, input logic sv, input logic [31:0] sd,
                      input logic ir);
        step(1'b1, e, 1'b0, 32'h0, rdy, sv, sd, ir);
    endtask

    task automatic redir(input logic e, input logic [31:0] rpc, input logic rdy, input logic sv,
                         input logic [31:0] sd, input logic ir);
        step(1'b1, e, 1'b1, rpc, rdy, sv, sd, ir);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs_count = 0;
        pc = 32'h0;
        rst_n = 1'b0;
        en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = 32'h0;
        bus.instr_ready = 1'b0;

        // Reset with en and redirect asserted: everything must stay quiet.
        step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
        check("rst_req_valid", o_req_valid, 1'b0);
        check("rst_instr_valid", o_instr_valid, 1'b0);
        check("rst_pc_ld", o_pc_ld, 1'b0);
        check("rst_pc_next", o_pc_next, 32'h0);
        check("rst_req_addr", o_req_addr, 32'h0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_instr_pc", o_instr_pc, 32'h0);

        // Basic fetch from pc=0 with zero-wait memory.
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("idle_req_valid", o_req_valid, 1'b0);
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("c1_req_valid", o_req_valid, 1'b1);
        check("c1_req_addr", o_req_addr, 32'h0);
        check("c1_instr_valid", o_instr_valid, 1'b0);
        push_expect(32'h00500093, 32'h0);
        go(1'b1, 1'b0, 1'b1, 32'h00500093, 1'b0);
        check("c2_pc_ld", o_pc_ld, 1'b1);
        check("c2_pc_next", o_pc_next, 32'h4);
        check("c2_instr_valid", o_instr_valid, 1'b0);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("c3_instr_valid", o_instr_valid, 1'b1);

        // Memory not ready for 5 cycles: request held, single handshake.
        hs_before = hs_count;
        for (int i = 0; i < 5; i++) begin
            go(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            check("stall_req_valid", o_req_valid, 1'b1);
            check("stall_req_addr", o_req_addr, 32'h4);
        end
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_hs_addr", o_req_addr, 32'h4);
        push_expect(32'h11111111, 32'h4);
        go(1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("stall_hs_count", hs_count - hs_before, 1);

        // Redirect in WAIT, stale response two cycles later.
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("r3_req_addr", o_req_addr, 32'h8);
        redir(1'b1, 32'h103, 1'b0, 1'b0, 32'h0, 1'b0);
        check("r3_pc_ld", o_pc_ld, 1'b1);
        check("r3_pc_next", o_pc_next, 32'h100);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("drop_req_valid", o_req_valid, 1'b0);
        check("drop_instr_valid", o_instr_valid, 1'b0);
        go(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        check("drop_rsp_pc_ld", o_pc_ld, 1'b0);
        check("drop_rsp_instr_valid", o_instr_valid, 1'b0);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("r3_next_req_valid", o_req_valid, 1'b1);
        check("r3_next_req_addr", o_req_addr, 32'h100);
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        push_expect(32'h22222222, 32'h100);
        go(1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Abandon in REQ, then fetch at the top of memory and check wrap.
        redir(1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        check("abandon_req_addr", o_req_addr, 32'h104);
        check("abandon_pc_next", o_pc_next, 32'hFFFFFFFC);
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("top_req_addr", o_req_addr, 32'hFFFFFFFC);
        push_expect(32'h33333333, 32'hFFFFFFFC);
        go(1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0);
        check("wrap_pc_ld", o_pc_ld, 1'b1);
        check("wrap_pc_next", o_pc_next, 32'h0);

        // Decode stalls 4 cycles: output stable, no new request.
        hs_before = hs_count;
        for (int i = 0; i < 4; i++) begin
            go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            check("hold_instr_valid", o_instr_valid, 1'b1);
            check("hold_instr", o_instr, 32'h33333333);
            check("hold_instr_pc", o_instr_pc, 32'hFFFFFFFC);
            check("hold_req_valid", o_req_valid, 1'b0);
        end
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("hold_hs_count", hs_count - hs_before, 0);

        // Reset during WAIT, late response afterwards.
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("w5_req_addr", o_req_addr, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("midrst_req_valid", o_req_valid, 1'b0);
        check("midrst_pc_ld", o_pc_ld, 1'b0);
        go(1'b0, 1'b0, 1'b1, 32'hBADBAD00, 1'b0);
        check("postrst_pc_ld", o_pc_ld, 1'b0);
        check("postrst_pc_next", o_pc_next, 32'h0);
        check("postrst_req_valid", o_req_valid, 1'b0);
        check("postrst_instr_valid", o_instr_valid, 1'b0);
        check("postrst_instr", o_instr, 32'h0);
        check("postrst_instr_pc", o_instr_pc, 32'h0);
        go(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("late_rsp_instr", o_instr, 32'h0);

        // Redirect in IDLE, then redirect coincident with the request handshake.
        redir(1'b0, 32'h201, 1'b0, 1'b0, 32'h0, 1'b0);
        check("idle_redir_pc_ld", o_pc_ld, 1'b1);
        check("idle_redir_pc_next", o_pc_next, 32'h200);
        go(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("idle_stay_req_valid", o_req_valid, 1'b0);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        redir(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0);
        check("hs_redir_req_addr", o_req_addr, 32'h200);
        check("hs_redir_pc_next", o_pc_next, 32'h300);
        redir(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
        check("drop_redir_req_valid", o_req_valid, 1'b0);
        check("drop_redir_pc_next", o_pc_next, 32'h400);
        go(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        check("drop2_instr_valid", o_instr_valid, 1'b0);
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("r6_req_addr", o_req_addr, 32'h400);
        go(1'b1, 1'b0, 1'b1, 32'h44444444, 1'b0);

        // Redirect while presenting an instruction abandons it.
        redir(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
        check("out_redir_instr_valid", o_instr_valid, 1'b1);
        check("out_redir_instr", o_instr, 32'h44444444);
        check("out_redir_instr_pc", o_instr_pc, 32'h400);
        check("out_redir_pc_next", o_pc_next, 32'h500);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("out_drop_instr_valid", o_instr_valid, 1'b0);
        check("out_drop_req_addr", o_req_addr, 32'h500);

        // Redirect coincident with the response discards it.
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        redir(1'b1, 32'h600, 1'b0, 1'b1, 32'h55555555, 1'b0);
        check("rsp_redir_pc_next", o_pc_next, 32'h600);
        go(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rsp_redir_req_valid", o_req_valid, 1'b1);
        check("rsp_redir_req_addr", o_req_addr, 32'h600);
        check("rsp_redir_instr_valid", o_instr_valid, 1'b0);
        go(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        push_expect(32'h66666666, 32'h600);
        go(1'b1, 1'b0, 1'b1, 32'h66666666, 1'b0);
        go(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        go(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("park_req_valid", o_req_valid, 1'b0);
        check("park_instr_valid", o_instr_valid, 1'b0);
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
